// File: rtl/tx_frame_scheduler.sv
// Round-robin two-source frame scheduler: emits fixed FRAME_LEN-byte frames (pad/truncate),
// marks sop/last and inserts a GAP_CYCLES gap. Define TX_IDLE_FILL_EN to emit idle-fill frames.
module tx_frame_scheduler #(
   parameter int unsigned FRAME_LEN  = 223,
   parameter int unsigned GAP_CYCLES = 8,
   parameter logic [7:0]  FILL_BYTE  = 8'h55,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [7:0]       s0_data,
   input  logic             s0_last,
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic [7:0]       s1_data,
   input  logic             s1_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [7:0]       m_data,
   output logic             m_last,
   output logic             m_sop,
   output logic             busy,
   output logic [1:0]       grant_id,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             trunc_err
);
   localparam int unsigned    BCW      = $clog2(FRAME_LEN);
   localparam logic [BCW-1:0] LAST_IDX = BCW'(FRAME_LEN - 1);
   localparam int unsigned    GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STREAM = 3'd1,
      S_PAD    = 3'd2,
      S_DRAIN  = 3'd3,
      S_GAP    = 3'd4,
      S_FILL   = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             rr_q, rr_d;
   logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             trunc_q, trunc_d;
`ifdef TX_IDLE_FILL_EN
   logic [3:0]       idle_cnt_q, idle_cnt_d;
`endif
   logic             src_valid;
   logic             src_last;
   logic [7:0]       src_data;
   logic             at_last;
   state_t           after_frame;

   assign src_valid   = grant_q ? s1_valid : s0_valid;
   assign src_last    = grant_q ? s1_last  : s0_last;
   assign src_data    = grant_q ? s1_data  : s0_data;
   assign at_last     = (byte_cnt_q == LAST_IDX);
   assign after_frame = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
   assign busy        = (state_q != S_IDLE);
   assign frame_cnt   = frame_cnt_q;
   assign trunc_err   = trunc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         grant_q     <= 1'b0;
         rr_q        <= 1'b0;
         byte_cnt_q  <= {BCW{1'b0}};
         gap_cnt_q   <= {GCW{1'b0}};
         frame_cnt_q <= {CNT_W{1'b0}};
         trunc_q     <= 1'b0;
`ifdef TX_IDLE_FILL_EN
         idle_cnt_q  <= 4'd0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_q        <= rr_d;
         byte_cnt_q  <= byte_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         trunc_q     <= trunc_d;
`ifdef TX_IDLE_FILL_EN
         idle_cnt_q  <= idle_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_d        = rr_q;
      byte_cnt_d  = byte_cnt_q;
      gap_cnt_d   = {GCW{1'b0}};
      frame_cnt_d = frame_cnt_q;
      trunc_d     = 1'b0;
`ifdef TX_IDLE_FILL_EN
      idle_cnt_d  = 4'd0;
`endif
      m_valid     = 1'b0;
      m_data      = FILL_BYTE;
      m_sop       = 1'b0;
      m_last      = 1'b0;
      s0_ready    = 1'b0;
      s1_ready    = 1'b0;
      grant_id    = 2'd2;
      case (state_q)
         S_IDLE: begin
            // rr_q names the source that wins a tie
            if (s0_valid || s1_valid) begin
               state_d = S_STREAM;
               grant_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
            end
`ifdef TX_IDLE_FILL_EN
            else if (idle_cnt_q == 4'd15) begin
               state_d = S_FILL;
            end else begin
               idle_cnt_d = idle_cnt_q + 4'd1;
            end
`else
            else begin
               state_d = S_IDLE;
            end
`endif
         end
         S_STREAM: begin
            grant_id = {1'b0, grant_q};
            m_valid  = src_valid;
            m_data   = src_data;
            m_sop    = (byte_cnt_q == {BCW{1'b0}});
            m_last   = at_last;
            s0_ready = m_ready & ~grant_q;
            s1_ready = m_ready & grant_q;
            if (src_valid && m_ready) begin
               if (at_last) begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
                  byte_cnt_d  = {BCW{1'b0}};
                  rr_d        = ~grant_q;
                  if (src_last) begin
                     state_d = after_frame;
                  end else begin
                     trunc_d = 1'b1;
                     state_d = S_DRAIN;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + BCW'(1);
                  state_d    = src_last ? S_PAD : S_STREAM;
               end
            end else begin
               state_d = S_STREAM;
            end
         end
         S_PAD, S_FILL: begin
            grant_id = (state_q == S_FILL) ? 2'd3 : {1'b0, grant_q};
            m_valid  = 1'b1;
            m_sop    = (byte_cnt_q == {BCW{1'b0}});
            m_last   = at_last;
            if (m_ready) begin
               if (at_last) begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
                  byte_cnt_d  = {BCW{1'b0}};
                  rr_d        = (state_q == S_PAD) ? ~grant_q : rr_q;
                  state_d     = after_frame;
               end else begin
                  byte_cnt_d = byte_cnt_q + BCW'(1);
               end
            end else begin
               byte_cnt_d = byte_cnt_q;
            end
         end
         S_DRAIN: begin
            // frame already counted; swallow the rest of the source message
            grant_id = {1'b0, grant_q};
            s0_ready = ~grant_q;
            s1_ready = grant_q;
            if (src_valid && src_last) begin
               state_d = after_frame;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GCW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule
